// File: rtl/mac_pipe.sv
// mac_pipe: pipelined signed multiply-accumulate with valid/ready handshakes; define MAC_SATURATION_EN to clamp results
module mac_pipe #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SCALE = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        out_valid,
  output logic                        out_sat,
  input  logic                        out_ready
);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  logic signed [A_WIDTH-1:0] a1;
  logic signed [B_WIDTH-1:0] b1;
  logic v1, f1, l1;
  logic signed [P_WIDTH-1:0] p2;
  logic v2, f2, l2;
  logic signed [ACC_WIDTH-1:0] acc, acc_next;
  logic v3;
  logic advance, sat;
  logic [OUT_WIDTH-1:0] res;
  assign advance = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign acc_next = f2 ? ACC_WIDTH'(p2) : acc + ACC_WIDTH'(p2);
`ifdef MAC_SATURATION_EN
  localparam logic signed [ACC_WIDTH-1:0] hi = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] lo = ~hi;
  logic signed [ACC_WIDTH-1:0] r;
  assign r = acc >>> OUT_SCALE;
  assign sat = (r > hi) || (r < lo);
  assign res = r > hi ? OUT_WIDTH'(hi) : r < lo ? OUT_WIDTH'(lo) : OUT_WIDTH'(r);
`else
  assign sat = 1'b0;
  assign res = OUT_WIDTH'(acc >>> OUT_SCALE);
`endif
  // v3 marks that acc holds a finished sequence; the output register picks it up one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, f1, l1, v2, f2, l2, v3} <= '0;
      a1 <= '0;
      b1 <= '0;
      p2 <= '0;
      acc <= '0;
      out <= '0;
      out_valid <= 1'b0;
      out_sat <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid;
      f1 <= in_valid && in_first;
      l1 <= in_valid && in_last;
      a1 <= a;
      b1 <= b;
      v2 <= v1;
      f2 <= f1;
      l2 <= l1;
      p2 <= P_WIDTH'(a1) * P_WIDTH'(b1);
      if (v2) acc <= acc_next;
      v3 <= v2 && l2;
      out_valid <= v3;
      if (v3) begin
        out <= res;
        out_sat <= sat;
      end
    end
  end
endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: randomized scoreboard bench for mac_pipe against a beat-level arithmetic model
module tb_mac_pipe;
  logic clk = 0, rst = 1;
  logic signed [15:0] a = 0, b = 0;
  logic in_valid = 0, in_first = 0, in_last = 0, in_ready;
  logic [15:0] out;
  logic out_valid, out_sat, out_ready = 1;

  typedef struct {logic [15:0] v; logic s;} exp_t;
  exp_t q[$];
  exp_t e;
  logic signed [39:0] macc = 0;
  int n_chk = 0, n_fail = 0, cyc = 0, pops = 0, last_pop = 0, gap = 0, holds = 0, bp_mode = 0, p0;
  logic held = 0, hsat;
  logic [15:0] hout;

  always #5 clk = ~clk;

  mac_pipe dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_sat(out_sat), .out_ready(out_ready)
  );

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model_res(logic signed [39:0] acc);
    longint r = longint'(acc) >>> 16;
    exp_t x;
`ifdef MAC_SATURATION_EN
    x.s = (r > 32767) || (r < -32768);
    x.v = r > 32767 ? 16'h7fff : r < -32768 ? 16'h8000 : 16'(r);
`else
    x.s = 1'b0;
    x.v = 16'(r);
`endif
    return x;
  endfunction

  // reference model: every accepted beat updates a wrapping 40-bit sum
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      macc = 0;
      q.delete();
    end else if (in_valid && in_ready) begin
      macc = (in_first ? 40'sd0 : macc) + 40'(longint'(a) * longint'(b));
      if (in_last) q.push_back(model_res(macc));
    end
  end

  always @(posedge clk) begin
    #2;
    out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!out_ready) begin
        chk("in_ready_low_on_hold", in_ready, 0);
        if (held) begin
          chk("hold_out", out, hout);
          chk("hold_sat", out_sat, hsat);
          holds++;
        end
        held = 1;
        hout = out;
        hsat = out_sat;
      end else begin
        held = 0;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got out=%0d with no result expected", out);
        end else begin
          e = q.pop_front();
          chk("out", out, e.v);
          chk("out_sat", out_sat, e.s);
          gap = cyc - last_pop;
          last_pop = cyc;
          pops++;
        end
      end
    end else held = 0;
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic signed [15:0] av, logic signed [15:0] bv, logic f, logic l);
    int n = 0;
    logic rdy;
    a = av;
    b = bv;
    in_first = f;
    in_last = l;
    in_valid = 1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (n > 500) begin
        $display("FAIL send_timeout: got no in_ready in %0d cycles, expected acceptance", n);
        $fatal(1, "send timeout");
      end
    end while (!rdy);
    in_valid = 0;
    in_first = 1'($urandom);
    in_last = 1'($urandom);
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      idle(1);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst = 0;
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    send(16384, 16384, 1, 1);
    chk("lat_t0", out_valid, 0);
    idle(1);
    chk("lat_t1", out_valid, 0);
    idle(1);
    chk("lat_t2", out_valid, 0);
    idle(1);
    chk("lat_t3", out_valid, 1);
    chk("lat_out", out, 4096);
    drain();
    send(-1, 1, 1, 1);
    drain();
    for (int i = 0; i < 4; i++) send(-32768, -32768, i == 0, i == 3);
    drain();
    send(256, 256, 1, 0);
    send(256, 256, 0, 0);
    send(256, 256, 0, 1);
    send(512, 512, 1, 1);
    drain();
    chk("b2b_gap", gap, 1);
    p0 = pops;
    holds = 0;
    fork
      for (int i = 0; i < 8; i++) send(16'(i), 16384, 1, 1);
      begin
        idle(3);
        bp_mode = 2;
        idle(5);
        bp_mode = 0;
      end
    join
    drain();
    chk("bp_count", pops - p0, 8);
    chk("bp_stall_seen", holds >= 3, 1);
    send(1024, 1024, 1, 0);
    send(1024, 1024, 0, 0);
    rst = 1;
    idle(1);
    rst = 0;
    chk("midrst_out_valid", out_valid, 0);
    p0 = pops;
    send(1024, 1024, 0, 1);
    idle(3);
    chk("midrst_out", out, 16);
    drain();
    chk("midrst_count", pops - p0, 1);
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    send(1, 1, 0, 1);
    bp_mode = 0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
